// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU pipeline: datapath widths, ALU opcode
// encoding and the EX-stage control bundle carried through ID/EX.
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int OP_W   = 4;

    // ALU opcode encoding shared with the execute-stage ALU.
    localparam logic [OP_W-1:0] ALU_OP_ADD = 4'b0000;
    localparam logic [OP_W-1:0] ALU_OP_SUB = 4'b0001;
    localparam logic [OP_W-1:0] ALU_OP_AND = 4'b0010;
    localparam logic [OP_W-1:0] ALU_OP_OR  = 4'b0011;
    localparam logic [OP_W-1:0] ALU_OP_XOR = 4'b0100;
    localparam logic [OP_W-1:0] ALU_OP_SLT = 4'b0101;
    localparam logic [OP_W-1:0] ALU_OP_SLL = 4'b0110;
    localparam logic [OP_W-1:0] ALU_OP_SRL = 4'b0111;

    // Control bits that travel with an instruction into EX.
    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic alusrc;
    } ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// -----------------------------------------------------------------------------
// fwd_unit
// Combinational forward-select for one source operand. The youngest producer
// (EX/MEM) wins over MEM/WB; register 0 is never forwarded.
//
// Ports:
//   i_idx            source register index of the operand
//   i_rf_data        value read from the register file in ID
//   i_exmem_*        EX/MEM write-back candidate (regwrite, rd, result)
//   i_memwb_*        MEM/WB write-back candidate (regwrite, rd, result)
//   o_data           forwarded operand value
// -----------------------------------------------------------------------------
module fwd_unit #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_idx,
    input  logic [DATA_W-1:0] i_rf_data,
    input  logic              i_exmem_regwrite,
    input  logic [REG_AW-1:0] i_exmem_rd,
    input  logic [DATA_W-1:0] i_exmem_result,
    input  logic              i_memwb_regwrite,
    input  logic [REG_AW-1:0] i_memwb_rd,
    input  logic [DATA_W-1:0] i_memwb_result,
    output logic [DATA_W-1:0] o_data
);

    logic w_hit_exmem;
    logic w_hit_memwb;

    assign w_hit_exmem = i_exmem_regwrite && (i_exmem_rd != '0) && (i_exmem_rd == i_idx);
    assign w_hit_memwb = i_memwb_regwrite && (i_memwb_rd != '0) && (i_memwb_rd == i_idx);

    // NOTE: every path through a combinational block assigns the output,
    // otherwise synthesis infers a latch to remember the missing case.
    always_comb begin
        o_data = i_rf_data;
        if (w_hit_exmem) begin
            o_data = i_exmem_result;
        end else if (w_hit_memwb) begin
            o_data = i_memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register feeding the execute-stage ALU. Registers decoded ID
// fields, forwards operands from EX/MEM and MEM/WB, detects load-use hazards
// (stalling IF/ID and inserting a bubble), and honours downstream stall and
// branch flush. Edge priority: flush > stall_in > load-use bubble > load.
//
// Optional build macro: IDEX_PERF_CNT_EN enables the bubble/flush performance
// counters; without it both counter ports read 0.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   id_*                             decoded instruction from ID
//   stall_in, flush                  downstream hold, branch redirect
//   exmem_*, memwb_*                 forwarding sources
//   ex_valid, ex_a, ex_b, ex_alu_op  ALU-facing outputs
//   ex_store_data, ex_rd, ex_*ctl    store data, destination, control bits
//   hazard_stall                     freeze PC and IF/ID on load-use
//   perf_bubble_cnt, perf_flush_cnt  performance counters
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int REG_AW = cpu_pkg::REG_AW,
    parameter int OP_W   = cpu_pkg::OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [OP_W-1:0]   id_alu_op,
    input  logic              id_alusrc,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              stall_in,
    input  logic              flush,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [OP_W-1:0]   ex_alu_op,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              hazard_stall,
    output logic [31:0]       perf_bubble_cnt,
    output logic [31:0]       perf_flush_cnt
);

    import cpu_pkg::*;

    localparam ex_ctrl_t BUBBLE_CTRL = '0;

    logic              r_valid;
    ex_ctrl_t          r_ctrl;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [OP_W-1:0]   r_alu_op;

    ex_ctrl_t          w_id_ctrl;
    logic              w_load_use;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    assign w_id_ctrl = '{regwrite: id_regwrite, memread: id_memread,
                         memwrite: id_memwrite, alusrc: id_alusrc};

    // A load in EX produces its value too late for the ID instruction.
    // rt only counts as a source when it feeds the ALU or is store data.
    assign w_load_use = r_valid && r_ctrl.memread && (r_rd != '0) && id_valid &&
                        ((r_rd == id_rs) ||
                         ((r_rd == id_rt) && (!id_alusrc || id_memwrite)));

    // A downstream hold already freezes the pipe, and a flush kills the
    // consumer, so neither needs a load-use stall.
    assign hazard_stall = w_load_use && !flush && !stall_in;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // Datapath registers are reset as well so ex_a/ex_b read a defined 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_ctrl    <= BUBBLE_CTRL;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_alu_op  <= '0;
        end else if (flush || (!stall_in && w_load_use)) begin
            // Bubble: only valid and controls matter; data fields are don't-care.
            r_valid <= 1'b0;
            r_ctrl  <= BUBBLE_CTRL;
        end else if (!stall_in) begin
            r_valid   <= id_valid;
            r_ctrl    <= w_id_ctrl;
            r_rs      <= id_rs;
            r_rt      <= id_rt;
            r_rd      <= id_rd;
            r_rs_data <= id_rs_data;
            r_rt_data <= id_rt_data;
            r_imm     <= id_imm;
            r_alu_op  <= id_alu_op;
        end
    end

    fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .i_idx           (r_rs),
        .i_rf_data       (r_rs_data),
        .i_exmem_regwrite(exmem_regwrite),
        .i_exmem_rd      (exmem_rd),
        .i_exmem_result  (exmem_result),
        .i_memwb_regwrite(memwb_regwrite),
        .i_memwb_rd      (memwb_rd),
        .i_memwb_result  (memwb_result),
        .o_data          (w_fwd_rs)
    );

    fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .i_idx           (r_rt),
        .i_rf_data       (r_rt_data),
        .i_exmem_regwrite(exmem_regwrite),
        .i_exmem_rd      (exmem_rd),
        .i_exmem_result  (exmem_result),
        .i_memwb_regwrite(memwb_regwrite),
        .i_memwb_rd      (memwb_rd),
        .i_memwb_result  (memwb_result),
        .o_data          (w_fwd_rt)
    );

    assign ex_valid      = r_valid;
    assign ex_a          = w_fwd_rs;
    assign ex_b          = r_ctrl.alusrc ? r_imm : w_fwd_rt;
    assign ex_store_data = w_fwd_rt;
    assign ex_alu_op     = r_alu_op;
    assign ex_rd         = r_rd;
    assign ex_regwrite   = r_ctrl.regwrite;
    assign ex_memread    = r_ctrl.memread;
    assign ex_memwrite   = r_ctrl.memwrite;

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_flush_cnt;

    // Counters freeze under a downstream hold; wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else if (!stall_in) begin
            if (hazard_stall) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
            if (flush && id_valid) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign perf_bubble_cnt = r_bubble_cnt;
    assign perf_flush_cnt  = r_flush_cnt;
`else
    assign perf_bubble_cnt = '0;
    assign perf_flush_cnt  = '0;
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage that directly feeds the execute-stage ALU (A_in, B_in, ALU_op).
- Registers decoded instruction fields from ID.
- Resolves operand forwarding from the EX/MEM and MEM/WB stages.
- Detects load-use hazards, stalling IF/ID and inserting a bubble into EX. Honours downstream stall and branch flush.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-index width.
- OP_W, 4, ALU_op width; matches the ALU opcode encoding.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt, id_rd  in  REG_AW  source/destination indices.
- id_rs_data, id_rt_data  in  DATA_W  register-file read data.
- id_imm  in  DATA_W  sign/zero-extended immediate.
- id_alu_op  in  OP_W  ALU opcode.
- id_alusrc  in  1  1 = B operand is the immediate.
- id_regwrite, id_memread, id_memwrite  in  1  control bits.
- stall_in  in  1  downstream (MEM) stall; hold this stage.
- flush  in  1  branch/jump redirect; kill the ID instruction.
- exmem_regwrite  in  1, exmem_rd  in  REG_AW, exmem_result  in  DATA_W  EX/MEM forward source.
- memwb_regwrite  in  1, memwb_rd  in  REG_AW, memwb_result  in  DATA_W  MEM/WB forward source.
- ex_valid  out  1  EX holds a real instruction.
- ex_a, ex_b  out  DATA_W  ALU operands (forwarded).
- ex_alu_op  out  OP_W  to the ALU.
- ex_store_data  out  DATA_W  forwarded rt value for stores.
- ex_rd  out  REG_AW; ex_regwrite, ex_memread, ex_memwrite  out  1.
- hazard_stall  out  1  freeze PC and IF/ID (load-use).
- perf_bubble_cnt, perf_flush_cnt  out  32  performance counters (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - All registers clear: valid=0, control bits=0, indices=0, data=0.
  - Outputs: ex_valid=0, ex_regwrite=0, ex_memread=0, ex_memwrite=0, ex_rd=0, ex_alu_op=0, ex_a=0, ex_b=0, ex_store_data=0, hazard_stall=0, counters=0.
- Latency: one cycle from ID inputs to EX-side registers. Forwarding muxes are combinational on the registered values.
- Update priority at each rising edge, highest first:
  1. flush: load a bubble (valid=0, regwrite=0, memread=0, memwrite=0). Flush also wins over stall_in.
  2. stall_in: hold every register unchanged.
  3. load-use: load a bubble.
  4. Otherwise: load the ID fields; stored valid = id_valid.
- Load-use detection (combinational): hazard_stall=1 when ALL of the following hold:
  - ex_valid, ex_memread, and ex_rd!=0, id_valid, and !flush;
  - ex_rd==id_rs, OR (ex_rd==id_rt AND (!id_alusrc OR id_memwrite)).
- hazard_stall is forced to 0 while stall_in=1, because the downstream hold already freezes the pipe.
- Forwarding, per source operand (rs, rt):
  - Select exmem_result if exmem_regwrite && exmem_rd!=0 && exmem_rd==idx.
  - Else select memwb_result under the same conditions with memwb_*.
  - Else use the registered register-file data.
  - EX/MEM beats MEM/WB when both match. Register 0 is never forwarded.
- Operand outputs:
  - ex_a = forwarded rs.
  - ex_b = id_alusrc registered ? registered imm : forwarded rt.
  - ex_store_data = forwarded rt, always.
- Bubble rules: a bubble carries zero controls, and its ex_rd is don't-care. Downstream must gate on ex_valid/regwrite.
- Simultaneous flush and load-use: flush wins and hazard_stall=0.

Optional Feature:
- Macro IDEX_PERF_CNT_EN.
- When defined:
  - perf_bubble_cnt increments on each cycle a load-use bubble is loaded.
  - perf_flush_cnt increments on each flush edge where the killed instruction had id_valid=1.
  - Both are 32-bit, wrap 0xFFFFFFFF->0, and neither increments while stall_in=1.
- When undefined: the counter logic is absent and both ports are tied to 0.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W, REG_AW, OP_W;
  - ALU opcode constants, including ALU_OP_ADD=4'b0000;
  - a typedef for the EX control bundle {regwrite, memread, memwrite, alusrc}.
- One natural sub-module, fwd_unit: a combinational forward-select for a single operand, instantiated twice (rs, rt).

Test Plan:
1. Reset mid-run: assert rst_n=0 asynchronously between clock edges -> all outputs 0 immediately, with no clock edge needed.
2. EX/MEM forward:
   - Stimulus: EX holds rs=3 (RF data 0x11); exmem_regwrite=1, exmem_rd=3, exmem_result=0xDEADBEEF; memwb_rd=3, memwb_result=0x5.
   - Required: ex_a=0xDEADBEEF.
   - Repeat with exmem_rd=0 -> ex_a=0x5.
3. Load-use:
   - Stimulus: lw to r8 in EX; ID has add using rt=8, alusrc=0.
   - Required: hazard_stall=1 for one cycle; next cycle ex_valid=0, ex_regwrite=0, then the add enters.
   - Same with addi using rt=8 as destination -> no stall.
4. Priority:
   - flush=1 and stall_in=1 together -> bubble loaded, ex_valid=0.
   - stall_in=1 alone for 3 cycles -> ex_a, ex_b, ex_alu_op unchanged.
5. Immediate select: id_alusrc=1, id_imm=0xFFFFFFFC, rt forward active -> ex_b=0xFFFFFFFC and ex_store_data = forwarded rt.
6. With IDEX_PERF_CNT_EN: 2 load-use bubbles plus 1 valid flush -> perf_bubble_cnt=2, perf_flush_cnt=1. Without the macro, both read 0.
